// File: rtl/sseg_mux_disp_if.sv
// rtl/sseg_mux_disp_if.sv - display content bus and seven-segment pin bundle
interface sseg_mux_disp_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                load;
  logic [7:0]          sseg_ca;
  logic [DIGITS-1:0]   sseg_an;

  modport master (
    output value, dp, blank, load,
    input  sseg_ca, sseg_an
  );

  modport slave (
    input  value, dp, blank, load,
    output sseg_ca, sseg_an
  );
endinterface

// File: rtl/sseg_mux_disp.sv
// rtl/sseg_mux_disp.sv - time-multiplexed N-digit hex seven-segment driver
module sseg_mux_disp #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic           pclk,
  input  logic           rst,
  sseg_mux_disp_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW:0] GUARD_W = (CW+1)'(GUARD);

  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [7:0]          sseg_ca_q;
  logic [DIGITS-1:0]   sseg_an_q;

  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] supp;
  logic              zero_run;
  logic              dark;
  logic [7:0]        ca_nxt;
  logic [DIGITS-1:0] an_nxt;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    assign nib[g] = sh_value[4*g +: 4];
  end

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (nib[i] == 4'h0);
      supp[i]  = (LZ_SUPPRESS != 0) & zero_run;
    end
  end

  always_comb begin
    dark   = ({1'b0, cnt} < GUARD_W) | sh_blank[idx] | (supp[idx] & ~sh_dp[idx]);
    an_nxt = '1;
    if (!dark) an_nxt[idx] = 1'b0;
    ca_nxt = {~sh_dp[idx], supp[idx] ? 7'h7F : hex_seg(nib[idx])};
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      sh_value  <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      cnt       <= '0;
      idx       <= '0;
      sseg_ca_q <= 8'hFF;
      sseg_an_q <= '1;
    end else begin
      if (bus.load) begin
        sh_value <= bus.value;
        sh_dp    <= bus.dp;
        sh_blank <= bus.blank;
      end
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      sseg_ca_q <= ca_nxt;
      sseg_an_q <= an_nxt;
    end
  end

  assign bus.sseg_ca = sseg_ca_q;
  assign bus.sseg_an = sseg_an_q;
endmodule
